// File: rtl/alu_seq.sv
// Micro-sequencer: runs a small stored program against an external ALU and writes results into a 4-entry register file.
// Optional build macro ALU_SEQ_TIMEOUT_EN adds a WAIT-state response timeout that raises err_to.
module alu_seq #(
  parameter int D_BW = 4,
  parameter int I_BW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              prog_we,
  input  logic [2:0]        prog_addr,
  input  logic [I_BW+5:0]   prog_wdata,
  input  logic [2:0]        prog_len,
  input  logic              rf_we,
  input  logic [1:0]        rf_waddr,
  input  logic [D_BW-1:0]   rf_wdata,
  input  logic [1:0]        rf_raddr,
  output logic [D_BW-1:0]   rf_rdata,
  output logic              alu_en,
  output logic [I_BW-1:0]   alu_cmd,
  output logic [D_BW-1:0]   alu_da,
  output logic [D_BW-1:0]   alu_db,
  input  logic              alu_rsp_en,
  input  logic              alu_rsp_of,
  input  logic              alu_rsp_ofb,
  input  logic [D_BW-1:0]   alu_rsp_dat,
  output logic              busy,
  output logic              done,
  output logic              err_of,
  output logic              err_to
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        pc_q, pc_d;
  logic              alu_en_q, alu_en_d;
  logic [I_BW-1:0]   alu_cmd_q, alu_cmd_d;
  logic [D_BW-1:0]   alu_da_q, alu_da_d;
  logic [D_BW-1:0]   alu_db_q, alu_db_d;
  logic              done_q, done_d;
  logic              err_of_q, err_of_d;
  logic [D_BW-1:0]   rf_q [4];
  logic [I_BW+5:0]   prog_q [8];

  logic              host_rf_we_s;
  logic              host_prog_we_s;
  logic              wb_en_s;
  logic [1:0]        wb_dst_s;
  logic [2:0]        fetch_pc_s;
  logic [I_BW-1:0]   fetch_cmd_s;
  logic [1:0]        fetch_srca_s;
  logic [1:0]        fetch_srcb_s;
  logic [D_BW-1:0]   op_a_s;
  logic [D_BW-1:0]   op_b_s;
  logic              unused_ofb_s;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [2:0]        to_cnt_q, to_cnt_d;
  logic              err_to_q, err_to_d;
`endif

  assign unused_ofb_s   = alu_rsp_ofb;
  assign host_rf_we_s   = rf_we   && (state_q == S_IDLE);
  assign host_prog_we_s = prog_we && (state_q == S_IDLE);
  assign wb_en_s        = alu_rsp_en && (state_q == S_WAIT);
  assign wb_dst_s       = prog_q[pc_q][5:4];

  // The next instruction is fetched while leaving IDLE or WAIT, so its pc is 0 or pc+1.
  assign fetch_pc_s   = (state_q == S_IDLE) ? 3'd0 : (pc_q + 3'd1);
  assign fetch_cmd_s  = prog_q[fetch_pc_s][I_BW+5:6];
  assign fetch_srca_s = prog_q[fetch_pc_s][3:2];
  assign fetch_srcb_s = prog_q[fetch_pc_s][1:0];

  // Writeback lands on the same edge as the next operand capture, so bypass it.
  assign op_a_s = (wb_en_s && (fetch_srca_s == wb_dst_s)) ? alu_rsp_dat : rf_q[fetch_srca_s];
  assign op_b_s = (wb_en_s && (fetch_srcb_s == wb_dst_s)) ? alu_rsp_dat : rf_q[fetch_srcb_s];

  // Next-state and registered-output logic for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    alu_en_d  = 1'b0;
    alu_cmd_d = alu_cmd_q;
    alu_da_d  = alu_da_q;
    alu_db_d  = alu_db_q;
    done_d    = 1'b0;
    err_of_d  = err_of_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    err_to_d  = err_to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          pc_d      = 3'd0;
          err_of_d  = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
          err_to_d  = 1'b0;
`endif
          alu_en_d  = 1'b1;
          alu_cmd_d = fetch_cmd_s;
          alu_da_d  = op_a_s;
          alu_db_d  = op_b_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
        to_cnt_d = 3'd0;
`endif
      end
      S_WAIT: begin
        if (alu_rsp_en) begin
          err_of_d = err_of_q | alu_rsp_of;
          if (pc_q == prog_len) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_ISSUE;
            pc_d      = pc_q + 3'd1;
            alu_en_d  = 1'b1;
            alu_cmd_d = fetch_cmd_s;
            alu_da_d  = op_a_s;
            alu_db_d  = op_b_s;
          end
`ifdef ALU_SEQ_TIMEOUT_EN
        end else if (to_cnt_q == 3'd7) begin
          err_to_d = 1'b1;
          state_d  = S_DONE;
          done_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 3'd1;
        end
`else
        end else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 3'd0;
      alu_en_q  <= 1'b0;
      alu_cmd_q <= '0;
      alu_da_q  <= '0;
      alu_db_q  <= '0;
      done_q    <= 1'b0;
      err_of_q  <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      to_cnt_q  <= 3'd0;
      err_to_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      alu_en_q  <= alu_en_d;
      alu_cmd_q <= alu_cmd_d;
      alu_da_q  <= alu_da_d;
      alu_db_q  <= alu_db_d;
      done_q    <= done_d;
      err_of_q  <= err_of_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      err_to_q  <= err_to_d;
`endif
    end
  end

  // Register file: ALU writeback in WAIT, host preload only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en_s) begin
      rf_q[wb_dst_s] <= alu_rsp_dat;
    end else if (host_rf_we_s) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Program memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (host_prog_we_s) begin
      prog_q[prog_addr] <= prog_wdata;
    end
  end

  assign rf_rdata = rf_q[rf_raddr];
  assign alu_en   = alu_en_q;
  assign alu_cmd  = alu_cmd_q;
  assign alu_da   = alu_da_q;
  assign alu_db   = alu_db_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);
  assign err_of   = err_of_q;
`ifdef ALU_SEQ_TIMEOUT_EN
  assign err_to   = err_to_q;
`else
  assign err_to   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq: a bench-side ALU model answers requests one cycle later,
// and a program-level reference model predicts requests, latency, register file and flags.
module tb_alu_seq;
  localparam int D_BW = 4;
  localparam int I_BW = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            prog_we;
  logic [2:0]      prog_addr;
  logic [I_BW+5:0] prog_wdata;
  logic [2:0]      prog_len;
  logic            rf_we;
  logic [1:0]      rf_waddr;
  logic [D_BW-1:0] rf_wdata;
  logic [1:0]      rf_raddr;
  logic [D_BW-1:0] rf_rdata;
  logic            alu_en;
  logic [I_BW-1:0] alu_cmd;
  logic [D_BW-1:0] alu_da;
  logic [D_BW-1:0] alu_db;
  wire             alu_rsp_en;
  wire             alu_rsp_of;
  wire             alu_rsp_ofb;
  wire [D_BW-1:0]  alu_rsp_dat;
  logic            busy;
  logic            done;
  logic            err_of;
  logic            err_to;

  alu_seq #(.D_BW(D_BW), .I_BW(I_BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_len(prog_len),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_en(alu_en), .alu_cmd(alu_cmd), .alu_da(alu_da), .alu_db(alu_db),
    .alu_rsp_en(alu_rsp_en), .alu_rsp_of(alu_rsp_of), .alu_rsp_ofb(alu_rsp_ofb), .alu_rsp_dat(alu_rsp_dat),
    .busy(busy), .done(done), .err_of(err_of), .err_to(err_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Bench ALU: cmd 0 ADD (carry -> of), 1 SUB b-a (borrow -> of), 2 XOR, 3 AND, others OR.
  logic       ovr_en  = 1'b0;
  logic [3:0] ovr_dat = 4'd0;
  logic       ovr_of  = 1'b0;

  function automatic void alu_fn(input logic [3:0] cmd, input logic [3:0] a, input logic [3:0] b,
                                 output logic [3:0] d, output logic of);
    logic [4:0] t;
    of = 1'b0;
    case (cmd)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; d = t[3:0]; of = t[4]; end
      4'd1: begin d = b - a; of = (b < a); end
      4'd2: d = a ^ b;
      4'd3: d = a & b;
      default: d = a | b;
    endcase
    if (ovr_en) begin d = ovr_dat; of = ovr_of; end
  endfunction

  typedef struct { logic [3:0] cmd; logic [3:0] a; logic [3:0] b; } req_t;
  req_t exp_q[$];

  logic       model_on = 1'b0;
  logic       m_en = 1'b0, m_of = 1'b0, m_ofb = 1'b0;
  logic [3:0] m_dat = 4'd0;
  logic       man_en = 1'b0, man_of = 1'b0;
  logic [3:0] man_dat = 4'd0;
  logic       pend = 1'b0, pend_of = 1'b0;
  logic [3:0] pend_dat = 4'd0;
  int         en_cnt = 0;

  assign alu_rsp_en  = model_on ? m_en  : man_en;
  assign alu_rsp_of  = model_on ? m_of  : man_of;
  assign alu_rsp_dat = model_on ? m_dat : man_dat;
  assign alu_rsp_ofb = model_on ? m_ofb : 1'b1;

  always @(negedge clk) begin
    req_t r;
    if (model_on) begin
      m_en  = pend;
      m_dat = pend_dat;
      m_of  = pend_of;
      m_ofb = 1'($urandom);
      pend  = 1'b0;
      if (alu_en) begin
        en_cnt++;
        alu_fn(alu_cmd, alu_da, alu_db, pend_dat, pend_of);
        pend = 1'b1;
        if (exp_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
        else begin
          r = exp_q.pop_front();
          check("alu_cmd", alu_cmd, r.cmd);
          check("alu_da", alu_da, r.a);
          check("alu_db", alu_db, r.b);
        end
      end
    end else begin
      pend = 1'b0;
      m_en = 1'b0;
    end
  end

  logic [3:0] rf_m [4];
  logic [9:0] prog_m [8];

  task automatic rf_load(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk); rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(negedge clk); rf_we = 1'b0;
    rf_m[a] = d;
  endtask

  task automatic prog_load(input logic [2:0] a, input logic [9:0] w);
    @(negedge clk); prog_we = 1'b1; prog_addr = a; prog_wdata = w;
    @(negedge clk); prog_we = 1'b0;
    prog_m[a] = w;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rf_raddr = 2'(i); #1;
      check(tag, rf_rdata, rf_m[i]);
    end
  endtask

  // Execute the program in the reference, then run the DUT and compare.
  task automatic run_prog(input int len, input bit noise);
    logic [3:0] d;
    logic of, of_acc;
    logic [9:0] w;
    int n;
    bit got;
    of_acc = 1'b0;
    exp_q.delete();
    for (int i = 0; i <= len; i++) begin
      w = prog_m[i];
      exp_q.push_back('{w[9:6], rf_m[w[3:2]], rf_m[w[1:0]]});
      alu_fn(w[9:6], rf_m[w[3:2]], rf_m[w[1:0]], d, of);
      rf_m[w[5:4]] = d;
      of_acc |= of;
    end
    en_cnt = 0;
    prog_len = 3'(len);
    @(negedge clk); start = 1'b1;
    n = 0; got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = 1'b0;
      if (noise && n == 2) begin
        start = 1'b1; rf_we = 1'b1; rf_waddr = 2'($urandom); rf_wdata = 4'($urandom);
        prog_we = 1'b1; prog_addr = 3'(len); prog_wdata = 10'($urandom);
      end
      if (noise && n == 3) begin start = 1'b0; rf_we = 1'b0; prog_we = 1'b0; end
      if (done) got = 1'b1;
    end
    check("done_latency", n, 2 * (len + 1) + 1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("alu_en_pulses", en_cnt, len + 1);
    check("req_left", exp_q.size(), 0);
    check("err_of", err_of, of_acc);
    exp_q.delete();
    check_rf("rf");
  endtask

  initial begin
    int n;
    bit got;
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = 3'd0; prog_wdata = '0; prog_len = 3'd0;
    rf_we = 1'b0; rf_waddr = 2'd0; rf_wdata = 4'd0; rf_raddr = 2'd0;
    for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_alu_en", alu_en, 1'b0);
    check("rst_alu_cmd", alu_cmd, 4'd0);
    check("rst_alu_da", alu_da, 4'd0);
    check("rst_alu_db", alu_db, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err_of", err_of, 1'b0);
    check("rst_err_to", err_to, 1'b0);
    rst_n = 1'b1;
    check_rf("rst_rf");
    model_on = 1'b1;

    // Single ADD.
    rf_load(2'd0, 4'd5); rf_load(2'd1, 4'd3);
    prog_load(3'd0, {4'd0, 2'd2, 2'd0, 2'd1});
    run_prog(0, 1'b0);
    rf_raddr = 2'd2; #1; check("add_rf2", rf_rdata, 4'd8);

    // Forced overflow response; flag is sticky until the next start.
    rf_load(2'd0, 4'd9); rf_load(2'd1, 4'd9);
    ovr_en = 1'b1; ovr_dat = 4'd15; ovr_of = 1'b1;
    run_prog(0, 1'b0);
    ovr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("err_of_sticky", err_of, 1'b1);
    rf_raddr = 2'd2; #1; check("ovr_rf2", rf_rdata, 4'd15);

    // Two-instruction program with a dependent second operand.
    rf_load(2'd0, 4'd2); rf_load(2'd1, 4'd7);
    prog_load(3'd0, {4'd1, 2'd2, 2'd0, 2'd1});
    prog_load(3'd1, {4'd2, 2'd3, 2'd2, 2'd0});
    run_prog(1, 1'b0);
    rf_raddr = 2'd2; #1; check("seq_rf2", rf_rdata, 4'd5);
    rf_raddr = 2'd3; #1; check("seq_rf3", rf_rdata, 4'd7);
    check("err_of_cleared", err_of, 1'b0);

    // Random programs, with busy-time start/rf/prog writes on some runs.
    for (int it = 0; it < 14; it++) begin
      int len;
      for (int r = 0; r < 4; r++) rf_load(2'(r), 4'($urandom));
      for (int p = 0; p < 8; p++)
        prog_load(3'(p), {4'($urandom_range(0, 5)), 2'($urandom), 2'($urandom), 2'($urandom)});
      len = (it == 0) ? 7 : $urandom_range(0, 7);
      run_prog(len, (it % 2) == 1);
    end
    check("err_to_idle", err_to, 1'b0);

    // ALU never answers.
    model_on = 1'b0;
    rf_load(2'd0, 4'd1); rf_load(2'd1, 4'd2); rf_load(2'd2, 4'd3); rf_load(2'd3, 4'd4);
    prog_load(3'd0, {4'd0, 2'd3, 2'd0, 2'd1});
    prog_len = 3'd0;
    @(negedge clk); start = 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
    n = 0; got = 1'b0;
    while (n < 50 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = 1'b0;
      if (done) got = 1'b1;
    end
    check("to_latency", n, 10);
    check("to_err_to", err_to, 1'b1);
    @(posedge clk); #1;
    check("to_busy", busy, 1'b0);
    check_rf("to_rf");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
`else
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    check("stall_busy", busy, 1'b1);
    check("stall_done", done, 1'b0);
    check("stall_err_to", err_to, 1'b0);
`endif

    // Reset while waiting, then a stale response after release.
    rst_n = 1'b0; #1;
    check("abort_busy", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
    man_en = 1'b1; man_dat = 4'hA; man_of = 1'b1;
    repeat (2) @(negedge clk);
    man_en = 1'b0; man_of = 1'b0;
    check("late_busy", busy, 1'b0);
    check("late_done", done, 1'b0);
    check("late_alu_en", alu_en, 1'b0);
    check("late_alu_cmd", alu_cmd, 4'd0);
    check("late_alu_da", alu_da, 4'd0);
    check("late_alu_db", alu_db, 4'd0);
    check("late_err_of", err_of, 1'b0);
    check("late_err_to", err_to, 1'b0);
    check_rf("late_rf");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter D_BW, default 4, data width of ALU operands/results and register-file entries.
REQ-002 Parameter I_BW, default 4, ALU command width.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 prog_we / prog_addr / prog_wdata  input  1 / 3 / I_BW+6  program write port, 8 entries; word = {cmd[I_BW], dst[2], srca[2], srcb[2]}.
REQ-007 prog_len  input  3  index of last instruction to run (runs prog_len+1 instructions).
REQ-008 rf_we / rf_waddr / rf_wdata  input  1 / 2 / D_BW  host register-file preload port.
REQ-009 rf_raddr  input  2; rf_rdata  output  D_BW  combinational host read of register file.
REQ-010 alu_en / alu_cmd / alu_da / alu_db  output  1 / I_BW / D_BW / D_BW  ALU request, registered.
REQ-011 alu_rsp_en / alu_rsp_of / alu_rsp_ofb / alu_rsp_dat  input  1 / 1 / 1 / D_BW  ALU response.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse at program completion.
REQ-014 err_of  output  1  sticky overflow/underflow flag; err_to  output  1  sticky timeout flag.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, DONE; IDLE->ISSUE on start (pc cleared to 0, err_of/err_to cleared).
REQ-016 ISSUE: alu_en=1 for exactly one cycle, alu_cmd=prog[pc].cmd, alu_da=rf[srca], alu_db=rf[srcb]; next state WAIT.
REQ-017 alu_en SHALL be 0 in all states except ISSUE; alu_cmd/alu_da/alu_db hold last values otherwise.
REQ-018 WAIT: on alu_rsp_en=1, rf[dst]<=alu_rsp_dat; err_of<=err_of|alu_rsp_of; then DONE if pc==prog_len, else pc<=pc+1 and ISSUE.
REQ-019 alu_rsp_en outside WAIT SHALL be ignored (no rf write, no flag change).
REQ-020 Nominal per-instruction cost with 1-cycle-latency ALU: 2 cycles; done asserted 3 cycles after start sampled for a 1-instruction program.
REQ-021 DONE: done=1 for one cycle, next state IDLE.
REQ-022 dst may equal srca/srcb; operands SHALL be read in ISSUE, before writeback.
REQ-023 pc==7 with prog_len==7 SHALL end in DONE; pc SHALL never wrap.
REQ-024 start, prog_we, rf_we while busy SHALL be ignored.
REQ-025 alu_rsp_ofb SHALL be ignored.

Reset
REQ-026 rst_n low: state IDLE, pc=0, alu_en=0, alu_cmd=0, alu_da=0, alu_db=0, done=0, busy=0, err_of=0, err_to=0, all rf entries 0; program memory not reset.
REQ-027 Reset mid-run SHALL abort immediately; responses arriving after reset release SHALL be ignored (state IDLE).

Configuration
REQ-028 Macro ALU_SEQ_TIMEOUT_EN defined: 3-bit counter in WAIT; 8 cycles without alu_rsp_en -> err_to=1, no rf write, go to DONE.
REQ-029 Macro ALU_SEQ_TIMEOUT_EN undefined: no counter, WAIT persists indefinitely, err_to tied 0.

Verification
REQ-030 rf0=5, rf1=3, prog0={ADD,dst2,a0,b1}, len0, start; ALU model returns 8 -> alu_en one pulse cmd0/da5/db3, rf2=8, done 3 cycles after start, err_of=0.
REQ-031 rf0=9, rf1=9, ADD, model returns of=1 dat=15 -> rf2=15, err_of=1 held until next start clears it.
REQ-032 rf0=2, rf1=7, prog0={SUB,dst2,a0,b1}, prog1={XOR,dst3,a2,b0}, len1 -> rf2=5, rf3=7, two alu_en pulses, done 5 cycles after start.
REQ-033 With ALU_SEQ_TIMEOUT_EN, model never responds -> err_to=1 and done after 8 WAIT cycles, rf unchanged; without macro busy stays 1.
REQ-034 rst_n low during WAIT, late alu_rsp_en=1 dat=A after release -> all outputs reset values, rf all 0, busy 0.
REQ-035 start and rf_we (addr0, data F) pulsed while busy -> no restart, rf0 unchanged.
